// File: rtl/adc_chan_condition_if.sv
// Sample/control bundle between an ADC conditioning channel and its consumer.
// master drives raw samples and triggers; slave is the conditioning stage.
interface adc_chan_condition_if #(
    parameter int unsigned WIN_W = 10
);
    logic [12:0]      data_in;
    logic             trig;
    logic [WIN_W-1:0] window_len;
    logic [12:0]      data_out;
    logic             data_valid;
    logic [12:0]      baseline;
    logic             baseline_valid;
    logic             busy;
    logic             trig_overrun;

    modport master (
        output data_in, trig, window_len,
        input  data_out, data_valid, baseline, baseline_valid, busy, trig_overrun
    );

    modport slave (
        input  data_in, trig, window_len,
        output data_out, data_valid, baseline, baseline_valid, busy, trig_overrun
    );
endinterface

// File: rtl/adc_chan_condition.sv
// Per-channel ADC conditioning: bit-inversion restore, per-trigger pedestal measurement,
// then baseline-subtracted saturated samples over a programmable window.
module adc_chan_condition #(
    parameter logic [12:0] BITFLIP       = 13'h0000,
    parameter int unsigned BASELINE_LOG2 = 4,
    parameter int unsigned WIN_W         = 10
) (
    input logic                 clk357,
    input logic                 rst,
    adc_chan_condition_if.slave bus
);
    localparam int unsigned AW = 13 + BASELINE_LOG2;

    typedef enum logic [1:0] {StIdle, StBaseline, StActive} state_e;

    state_e                   state_q, state_d;
    logic [12:0]              s1_q;
    logic [AW-1:0]            acc_q, acc_d, acc_sum;
    logic [BASELINE_LOG2-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0]         win_cnt_q, win_cnt_d;
    logic [12:0]              data_out_q, data_out_d;
    logic                     data_valid_q, data_valid_d;
    logic [12:0]              baseline_q, baseline_d;
    logic                     baseline_valid_q, baseline_valid_d;
    logic                     overrun_q, overrun_d;
    logic [13:0]              diff;
    logic [12:0]              sat;

    always_ff @(posedge clk357) begin
        s1_q <= bus.data_in ^ BITFLIP;
    end

    // Sign-extended accumulate; the top 13 bits of the sum are the floor-divided mean.
    assign acc_sum = acc_q + {{BASELINE_LOG2{s1_q[12]}}, s1_q};
    assign diff    = {s1_q[12], s1_q} - {baseline_q[12], baseline_q};

    always_comb begin
        unique case (diff[13:12])
            2'b01:   sat = 13'h0fff;
            2'b10:   sat = 13'h1000;
            default: sat = diff[12:0];
        endcase
    end

    always_comb begin
        state_d          = state_q;
        acc_d            = acc_q;
        cnt_d            = cnt_q;
        win_cnt_d        = win_cnt_q;
        data_out_d       = data_out_q;
        data_valid_d     = 1'b0;
        baseline_d       = baseline_q;
        baseline_valid_d = 1'b0;
        // The final ACTIVE cycle still counts as busy, so a trig there is an overrun.
        overrun_d        = overrun_q | (bus.trig && (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (bus.trig) begin
                    state_d   = StBaseline;
                    win_cnt_d = bus.window_len;
                    acc_d     = '0;
                    cnt_d     = '0;
                end
            end
            StBaseline: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    baseline_d       = acc_sum[AW-1:BASELINE_LOG2];
                    baseline_valid_d = 1'b1;
                    state_d          = (win_cnt_q == '0) ? StIdle : StActive;
                end
            end
            StActive: begin
                data_out_d   = sat;
                data_valid_d = 1'b1;
                win_cnt_d    = win_cnt_q - 1'b1;
                if (win_cnt_q == WIN_W'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk357) begin
        if (rst) begin
            state_q          <= StIdle;
            acc_q            <= '0;
            cnt_q            <= '0;
            win_cnt_q        <= '0;
            data_out_q       <= '0;
            data_valid_q     <= 1'b0;
            baseline_q       <= '0;
            baseline_valid_q <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            cnt_q            <= cnt_d;
            win_cnt_q        <= win_cnt_d;
            data_out_q       <= data_out_d;
            data_valid_q     <= data_valid_d;
            baseline_q       <= baseline_d;
            baseline_valid_q <= baseline_valid_d;
            overrun_q        <= overrun_d;
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_valid     = data_valid_q;
    assign bus.baseline       = baseline_q;
    assign bus.baseline_valid = baseline_valid_q;
    assign bus.busy           = (state_q != StIdle);
    assign bus.trig_overrun   = overrun_q;
endmodule

// File: tb/tb_adc_chan_condition.sv
// Directed bench for adc_chan_condition: N = 16, BITFLIP = 13'h1685, stimulus given as
// corrected (post-XOR) values with hand-computed expected outputs.
module tb_adc_chan_condition;
    localparam logic [12:0] FLIP = 13'h1685;
    localparam int N = 16;

    logic clk357 = 1'b0;
    logic rst    = 1'b1;
    int   checks = 0;
    int   errors = 0;

    adc_chan_condition_if #(.WIN_W(10)) chan ();

    adc_chan_condition #(
        .BITFLIP      (FLIP),
        .BASELINE_LOG2(4),
        .WIN_W        (10)
    ) dut (
        .clk357(clk357),
        .rst   (rst),
        .bus   (chan)
    );

    always #5 clk357 = ~clk357;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk357);
        #1;
    endtask

    task automatic drive(input int v);
        chan.data_in = 13'(v) ^ FLIP;
    endtask

    // Trigger at c = 0; baseline samples alternate bl_e/bl_o; window samples are wa before
    // cycle sw and wb from it on; optional extra trig at cycle retrig.
    task automatic pulse(input string name, input int wl, input int bl_e, input int bl_o,
                         input int wa, input int wb, input int sw, input int retrig,
                         input int exp_base, input int exp_a, input int exp_b);
        int nvalid;
        nvalid = 0;
        chan.trig       = 1'b1;
        chan.window_len = 10'(wl);
        drive(bl_e);
        for (int c = 1; c <= wl + 20; c++) begin
            tick();
            chan.trig = 1'b0;
            if (c < N) drive((c % 2 == 0) ? bl_e : bl_o);
            else       drive((c < sw) ? wa : wb);
            if (c == retrig) begin
                chan.trig       = 1'b1;
                chan.window_len = 10'd9;
            end
            check($sformatf("%s busy c%0d", name, c), int'(chan.busy), (c <= N + wl) ? 1 : 0);
            check($sformatf("%s bvalid c%0d", name, c), int'(chan.baseline_valid),
                  (c == N + 1) ? 1 : 0);
            if (c == N + 1)
                check($sformatf("%s baseline", name), int'($signed(chan.baseline)), exp_base);
            if (c >= N + 2 && c < N + 2 + wl) begin
                check($sformatf("%s valid c%0d", name, c), int'(chan.data_valid), 1);
                check($sformatf("%s data c%0d", name, c), int'($signed(chan.data_out)),
                      (c - 2 < sw) ? exp_a : exp_b);
            end else begin
                check($sformatf("%s valid c%0d", name, c), int'(chan.data_valid), 0);
            end
            nvalid += int'(chan.data_valid);
        end
        check($sformatf("%s nvalid", name), nvalid, wl);
        if (wl > 0)
            check($sformatf("%s hold", name), int'($signed(chan.data_out)),
                  (N + wl - 1 < sw) ? exp_a : exp_b);
    endtask

    initial begin
        chan.trig       = 1'b0;
        chan.window_len = '0;
        drive(0);
        repeat (3) tick();
        check("rst data_out", int'(chan.data_out), 0);
        check("rst data_valid", int'(chan.data_valid), 0);
        check("rst baseline", int'(chan.baseline), 0);
        check("rst baseline_valid", int'(chan.baseline_valid), 0);
        check("rst busy", int'(chan.busy), 0);
        check("rst overrun", int'(chan.trig_overrun), 0);
        rst = 1'b0;
        tick();

        pulse("restore", 6, 0, 0, 0, 500, 20, 0, 0, 0, 500);
        pulse("subtract", 8, 100, 100, 2000, 2000, 0, 0, 100, 1900, 1900);
        pulse("floor", 2, -1, -2, 10, 10, 0, 0, -2, 12, 12);
        pulse("sat_hi", 3, -4096, -4096, 4095, 4095, 0, 0, -4096, 4095, 4095);
        pulse("sat_lo", 3, 4095, 4095, -4096, -4096, 0, 0, 4095, -4096, -4096);
        pulse("zero_win", 0, 7, 7, 0, 0, 0, 0, 7, 0, 0);
        check("overrun clear", int'(chan.trig_overrun), 0);

        pulse("overlap", 5, 20, 20, 25, 25, 0, 5, 20, 5, 5);
        check("overrun set", int'(chan.trig_overrun), 1);

        // Reset on the third valid cycle of a 10-sample window.
        chan.trig       = 1'b1;
        chan.window_len = 10'd10;
        drive(50);
        for (int c = 1; c <= 20; c++) begin
            tick();
            chan.trig = 1'b0;
            drive((c < N) ? 50 : 60);
        end
        check("midrst valid", int'(chan.data_valid), 1);
        check("midrst data", int'($signed(chan.data_out)), 10);
        check("midrst overrun", int'(chan.trig_overrun), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("postrst valid", int'(chan.data_valid), 0);
        check("postrst baseline", int'(chan.baseline), 0);
        check("postrst busy", int'(chan.busy), 0);
        check("postrst overrun", int'(chan.trig_overrun), 0);
        check("postrst data", int'(chan.data_out), 0);
        tick();

        pulse("after_rst", 4, 30, 30, 31, 31, 0, N + 4, 30, 1, 1);
        check("edge overrun", int'(chan.trig_overrun), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
